// File: rtl/pyjamask96_ctrl.sv
// Sequencer for the byte-serial pyjamask96 core: 16-cycle key/block load, start pulse, 12-byte collect.
// Result is held on out_block with out_valid until out_ready; only one request in flight (in_ready only in IDLE).
module pyjamask96_ctrl #(
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [95:0]  in_block,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [95:0]  out_block,
  output logic         busy,
  output logic         timeout_err,
  output logic         core_load,
  output logic         core_start,
  output logic [7:0]   core_byte_in,
  output logic [7:0]   core_byte_key_in,
  input  logic         core_valid,
  input  logic [7:0]   core_byte_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_GAP, S_START, S_WAIT, S_COLLECT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [95:0]   blk_q, blk_d;
  logic [127:0]  key_q, key_d;
  logic [95:0]   out_block_q, out_block_d;
  logic          timeout_err_q, timeout_err_d;
  logic          core_load_q, core_load_d;
  logic          core_start_q, core_start_d;
  logic [7:0]    core_byte_in_q, core_byte_in_d;
  logic [7:0]    core_byte_key_in_q, core_byte_key_in_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q            <= S_IDLE;
      cnt_q              <= '0;
      blk_q              <= '0;
      key_q              <= '0;
      out_block_q        <= '0;
      timeout_err_q      <= 1'b0;
      core_load_q        <= 1'b0;
      core_start_q       <= 1'b0;
      core_byte_in_q     <= '0;
      core_byte_key_in_q <= '0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      blk_q              <= blk_d;
      key_q              <= key_d;
      out_block_q        <= out_block_d;
      timeout_err_q      <= timeout_err_d;
      core_load_q        <= core_load_d;
      core_start_q       <= core_start_d;
      core_byte_in_q     <= core_byte_in_d;
      core_byte_key_in_q <= core_byte_key_in_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    blk_d         = blk_q;
    key_d         = key_q;
    out_block_d   = out_block_q;
    timeout_err_d = timeout_err_q;

    // cnt_q is the load index, start-cycle count, wait count or collect index depending on state
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          blk_d         = in_block;
          key_d         = in_key;
          timeout_err_d = 1'b0;
          out_block_d   = '0;
          cnt_d         = '0;
          state_d       = S_LOAD;
        end
      end
      S_LOAD: begin
        if (cnt_q == 8'd15) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_GAP: begin
        cnt_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        if (cnt_q == 8'(START_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WAIT: begin
        if (core_valid) begin
          out_block_d[95:88] = core_byte_out;
          cnt_d              = 8'd1;
          state_d            = S_COLLECT;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          cnt_d         = '0;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_COLLECT: begin
        if (core_valid) begin
          for (int i = 1; i < 12; i++) begin
            if (cnt_q == 8'(i)) out_block_d[95-8*i -: 8] = core_byte_out;
          end
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd11) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Core drive is decoded from the next state so the registered outputs line up with LOAD/START
    core_load_d        = (state_d == S_LOAD);
    core_start_d       = (state_d == S_START);
    core_byte_in_d     = '0;
    core_byte_key_in_d = '0;
    if (state_d == S_LOAD) begin
      for (int i = 0; i < 12; i++) begin
        if (cnt_d == 8'(i)) core_byte_in_d = blk_d[95-8*i -: 8];
      end
      for (int i = 0; i < 16; i++) begin
        if (cnt_d == 8'(i)) core_byte_key_in_d = key_d[127-8*i -: 8];
      end
    end
  end

  assign in_ready         = (state_q == S_IDLE);
  assign busy             = (state_q != S_IDLE);
  assign out_valid        = (state_q == S_DONE);
  assign out_block        = out_block_q;
  assign timeout_err      = timeout_err_q;
  assign core_load        = core_load_q;
  assign core_start       = core_start_q;
  assign core_byte_in     = core_byte_in_q;
  assign core_byte_key_in = core_byte_key_in_q;

endmodule

// File: tb/tb_pyjamask96_ctrl.sv
// Directed bench for pyjamask96_ctrl with a stub core that replays known ciphertext bytes.
module tb_pyjamask96_ctrl;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [95:0]  in_block;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [95:0]  out_block;
  logic         busy;
  logic         timeout_err;
  logic         core_load;
  logic         core_start;
  logic [7:0]   core_byte_in;
  logic [7:0]   core_byte_key_in;
  logic         core_valid;
  logic [7:0]   core_byte_out;

  pyjamask96_ctrl #(.START_CYCLES(2), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .busy(busy), .timeout_err(timeout_err),
    .core_load(core_load), .core_start(core_start),
    .core_byte_in(core_byte_in), .core_byte_key_in(core_byte_key_in),
    .core_valid(core_valid), .core_byte_out(core_byte_out)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] KAT_KEY = 128'h00112233445566778899aabbccddeeff;
  localparam logic [95:0]  KAT_PT  = 96'h50796a616d61736b39363a29;
  localparam logic [95:0]  KAT_CT  = 96'hca9c6e1abbde4edc27073da6;
  localparam logic [95:0]  ALT_PT  = 96'h0102030405060708090a0b0c;
  localparam logic [127:0] ALT_KEY = 128'hfedcba98765432100123456789abcdef;
  localparam logic [95:0]  ALT_CT  = 96'h13579bdf2468ace0f0e1d2c3;

  int n_cmp = 0;
  int n_bad = 0;

  // stub-core ciphertext and per-transaction observations
  logic [95:0] stub_ct;
  logic [7:0]  rec_in  [16];
  logic [7:0]  rec_key [16];
  int          h_load_cnt, h_first_load, h_last_load;
  int          h_start_cnt, h_start_first;
  int          h_out_e, h_terr_e;
  logic        h_terr_at1;
  logic [95:0] h_block;

  // One request through the controller; the stub answers 2 cycles after start falls.
  task automatic run_txn(input logic [95:0] blk, input logic [127:0] key,
                         input int gap_len, input bit never_valid);
    int e, go_at, sent, gap_done;
    bit start_seen;
    logic [95:0] ct;
    ct = stub_ct;
    h_load_cnt = 0; h_first_load = 0; h_last_load = 0;
    h_start_cnt = 0; h_start_first = 0; h_out_e = 0; h_terr_e = 0;
    h_terr_at1 = 1'bx; h_block = '0;
    for (int i = 0; i < 16; i++) begin rec_in[i] = 8'hxx; rec_key[i] = 8'hxx; end
    @(negedge clk);
    in_block = blk; in_key = key; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_block = ~blk; in_key = ~key;
    e = 1; go_at = -1; sent = 0; gap_done = 0; start_seen = 0;
    while (e < 120) begin
      if (e == 1) h_terr_at1 = timeout_err;
      if (core_load) begin
        if (h_load_cnt < 16) begin
          rec_in[h_load_cnt]  = core_byte_in;
          rec_key[h_load_cnt] = core_byte_key_in;
        end
        if (h_first_load == 0) h_first_load = e;
        h_last_load = e;
        h_load_cnt++;
      end
      if (core_start) begin
        h_start_cnt++;
        if (h_start_first == 0) h_start_first = e;
        start_seen = 1;
      end else if (start_seen && go_at < 0) begin
        go_at = e + 2;
      end
      if (out_valid) begin h_out_e = e; h_block = out_block; break; end
      if (timeout_err) begin h_terr_e = e; break; end
      core_valid = 1'b0;
      if (!never_valid && go_at >= 0 && e >= go_at && sent < 12) begin
        if (sent == 6 && gap_done < gap_len) begin
          gap_done++;
        end else begin
          core_valid    = 1'b1;
          core_byte_out = ct[95-8*sent -: 8];
          sent++;
        end
      end
      @(negedge clk);
      e++;
    end
    core_valid = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, core_load, core_start, busy, timeout_err} !== 6'b100000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 100000 (rdy,ovld,load,start,busy,terr)",
               {in_ready, out_valid, core_load, core_start, busy, timeout_err});
    end
    n_cmp++;
    if ({out_block, core_byte_in, core_byte_key_in} !== 112'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", {out_block, core_byte_in, core_byte_key_in});
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_kat();
    int held;
    stub_ct = KAT_CT;
    run_txn(KAT_PT, KAT_KEY, 0, 0);
    n_cmp++;
    if (h_block !== KAT_CT) begin
      n_bad++; $display("FAIL kat_block: got %h want %h", h_block, KAT_CT);
    end
    n_cmp++;
    if (h_out_e !== 34) begin
      n_bad++; $display("FAIL kat_latency: out_valid at cycle %0d want 34", h_out_e);
    end
    held = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_block === KAT_CT) held++;
    end
    n_cmp++;
    if (held !== 3) begin
      n_bad++; $display("FAIL kat_hold: out_valid held %0d cycles want 3", held);
    end
    release_out();
    n_cmp++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      n_bad++; $display("FAIL kat_release: got %b want 010 (ovld,rdy,busy)", {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_load_stream();
    int bad_in, bad_key;
    logic [95:0] pt;
    logic [7:0]  exp_in;
    pt = KAT_PT;
    stub_ct = KAT_CT;
    run_txn(KAT_PT, KAT_KEY, 0, 0);
    n_cmp++;
    if (h_load_cnt !== 16 || h_first_load !== 1 || h_last_load !== 16) begin
      n_bad++;
      $display("FAIL load_window: got cnt %0d first %0d last %0d want 16 1 16",
               h_load_cnt, h_first_load, h_last_load);
    end
    bad_in = 0; bad_key = 0;
    for (int i = 0; i < 16; i++) begin
      exp_in = (i < 12) ? pt[95-8*i -: 8] : 8'h00;
      if (rec_in[i] !== exp_in) bad_in++;
      if (rec_key[i] !== 8'(8'h11 * i)) bad_key++;
    end
    n_cmp++;
    if (bad_in !== 0) begin
      n_bad++; $display("FAIL load_byte_in: %0d wrong bytes want 0 (byte0 got %h want 50)", bad_in, rec_in[0]);
    end
    n_cmp++;
    if (bad_key !== 0) begin
      n_bad++; $display("FAIL load_key_in: %0d wrong bytes want 0 (byte15 got %h want ff)", bad_key, rec_key[15]);
    end
    n_cmp++;
    if (h_start_cnt !== 2 || h_start_first !== 18) begin
      n_bad++;
      $display("FAIL start_pulse: got %0d cycles from %0d want 2 from 18", h_start_cnt, h_start_first);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    int bad;
    stub_ct = KAT_CT;
    run_txn(KAT_PT, KAT_KEY, 0, 0);
    bad = 0;
    in_block = ALT_PT; in_key = ALT_KEY; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      core_valid = (i % 2 == 0); core_byte_out = 8'hee;
      @(negedge clk);
      if (out_block !== KAT_CT || out_valid !== 1'b1 || in_ready !== 1'b0 || core_load !== 1'b0) bad++;
    end
    in_valid = 1'b0; core_valid = 1'b0;
    n_cmp++;
    if (bad !== 0) begin
      n_bad++; $display("FAIL bp_stable: %0d bad cycles of 20 want 0", bad);
    end
    release_out();
    n_cmp++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      n_bad++; $display("FAIL bp_release: got %b want 010 (ovld,rdy,busy)", {out_valid, in_ready, busy});
    end
    stub_ct = ALT_CT;
    run_txn(ALT_PT, ALT_KEY, 0, 0);
    n_cmp++;
    if (h_block !== ALT_CT || rec_in[0] !== 8'h01 || rec_key[0] !== 8'hfe) begin
      n_bad++;
      $display("FAIL bp_second: block %h in0 %h key0 %h want %h 01 fe", h_block, rec_in[0], rec_key[0], ALT_CT);
    end
    release_out();
  endtask

  task automatic test_timeout();
    stub_ct = KAT_CT;
    run_txn(KAT_PT, KAT_KEY, 0, 1);
    n_cmp++;
    if (h_terr_e !== 36 || h_out_e !== 0) begin
      n_bad++; $display("FAIL timeout_when: terr at %0d out at %0d want 36 0", h_terr_e, h_out_e);
    end
    n_cmp++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      n_bad++; $display("FAIL timeout_idle: got %b want 100 (rdy,busy,ovld)", {in_ready, busy, out_valid});
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (timeout_err !== 1'b1) begin
      n_bad++; $display("FAIL timeout_sticky: got %b want 1", timeout_err);
    end
    run_txn(KAT_PT, KAT_KEY, 0, 0);
    n_cmp++;
    if (h_terr_at1 !== 1'b0 || h_block !== KAT_CT) begin
      n_bad++; $display("FAIL timeout_clear: terr %b block %h want 0 %h", h_terr_at1, h_block, KAT_CT);
    end
    release_out();
  endtask

  task automatic test_reset_midop();
    stub_ct = KAT_CT;
    @(negedge clk);
    in_block = KAT_PT; in_key = KAT_KEY; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    n_cmp++;
    if (core_load !== 1'b1 || core_byte_in !== 8'h6b || core_byte_key_in !== 8'h77) begin
      n_bad++;
      $display("FAIL midop_idx7: load %b in %h key %h want 1 6b 77", core_load, core_byte_in, core_byte_key_in);
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    n_cmp++;
    if ({in_ready, out_valid, core_load, core_start, busy, timeout_err} !== 6'b100000 ||
        {out_block, core_byte_in, core_byte_key_in} !== 112'h0) begin
      n_bad++;
      $display("FAIL midop_reset: ctrl %b data %h want 100000 0",
               {in_ready, out_valid, core_load, core_start, busy, timeout_err},
               {out_block, core_byte_in, core_byte_key_in});
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (core_load !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL midop_no_resume: load %b busy %b want 0 0", core_load, busy);
    end
    run_txn(KAT_PT, KAT_KEY, 0, 0);
    n_cmp++;
    if (h_block !== KAT_CT) begin
      n_bad++; $display("FAIL midop_kat: got %h want %h", h_block, KAT_CT);
    end
    release_out();
  endtask

  task automatic test_gapped_valid();
    stub_ct = KAT_CT;
    run_txn(KAT_PT, KAT_KEY, 3, 0);
    n_cmp++;
    if (h_block !== KAT_CT) begin
      n_bad++; $display("FAIL gap_block: got %h want %h", h_block, KAT_CT);
    end
    n_cmp++;
    if (h_out_e !== 37 || timeout_err !== 1'b0) begin
      n_bad++; $display("FAIL gap_timing: out at %0d terr %b want 37 0", h_out_e, timeout_err);
    end
    release_out();
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_block = '0; in_key = '0;
    out_ready = 1'b0; core_valid = 1'b0; core_byte_out = '0; stub_ct = KAT_CT;
    test_reset();
    test_kat();
    test_load_stream();
    test_back_to_back();
    test_timeout();
    test_reset_midop();
    test_gapped_valid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
